// File: rtl/mem_wb_stage.sv
// MEM/WB stage: retires ALU results directly and waits for data-memory load
// responses, aligning/extending them before a single-cycle register-file write.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_we,
  input  logic [4:0]  in_wr_addr,
  input  logic [31:0] in_alu_result,
  input  logic        in_mem_read,
  input  logic [2:0]  in_load_type,
  input  logic        flush,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  reg_W_addr,
  output logic [31:0] wdata,
  output logic        reg_we,
  output logic        err_timeout,
  output logic        err_misalign,
  output logic        err_spurious
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN} state_t;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [2:0] ltype;
    logic [1:0] off;
  } ld_req_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  ld_req_t     ld_q, ld_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        upd, commit_we;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;
  logic        set_to, set_mis, set_spur;
  logic        take, misaligned, expired;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign in_ready = (state_q == IDLE);
  // a flushed accept is consumed but dropped on the floor
  assign take     = in_valid && in_ready && !flush;
  assign expired  = (cnt_q >= TO_LAST);

  always_comb begin
    misaligned = 1'b0;
    case (in_load_type)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = in_alu_result[0];
      default:        misaligned = (in_alu_result[1:0] != 2'b00);
    endcase
  end

  // little-endian lane select at the captured offset
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (ld_q.off)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = ld_q.off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_q.ltype)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_d        = ld_q;
    cnt_d       = cnt_q;
    upd         = 1'b0;
    commit_we   = 1'b0;
    commit_addr = reg_W_addr;
    commit_data = wdata;
    set_to      = 1'b0;
    set_mis     = 1'b0;
    set_spur    = 1'b0;
    case (state_q)
      IDLE: begin
        set_spur = dmem_rvalid;
        if (take) begin
          if (!in_mem_read) begin
            upd         = 1'b1;
            commit_we   = in_reg_we && (in_wr_addr != 5'd0);
            commit_addr = in_wr_addr;
            commit_data = in_alu_result;
          end else begin
            ld_d    = '{we: in_reg_we, addr: in_wr_addr,
                        ltype: in_load_type, off: in_alu_result[1:0]};
            cnt_d   = 8'd0;
            set_mis = misaligned;
            state_d = misaligned ? DRAIN : WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          if (!flush) begin
            upd         = 1'b1;
            commit_we   = ld_q.we && (ld_q.addr != 5'd0);
            commit_addr = ld_q.addr;
            commit_data = ld_ext;
          end
        end else if (expired) begin
          set_to  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (flush) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
        end else if (expired) begin
          set_to  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ld_q         <= '0;
      cnt_q        <= 8'd0;
      reg_we       <= 1'b0;
      reg_W_addr   <= 5'd0;
      wdata        <= 32'd0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      reg_we  <= upd && commit_we;
      if (upd) begin
        reg_W_addr <= commit_addr;
        wdata      <= commit_data;
      end
      if (set_to)   err_timeout  <= 1'b1;
      if (set_mis)  err_misalign <= 1'b1;
      if (set_spur) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: linear stimulus with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_we = 1'b0;
  logic [4:0]  in_wr_addr = '0;
  logic [31:0] in_alu_result = '0;
  logic        in_mem_read = 1'b0;
  logic [2:0]  in_load_type = '0;
  logic        flush = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  reg_W_addr;
  logic [31:0] wdata;
  logic        reg_we;
  logic        err_timeout, err_misalign, err_spurious;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_we(in_reg_we), .in_wr_addr(in_wr_addr),
    .in_alu_result(in_alu_result), .in_mem_read(in_mem_read),
    .in_load_type(in_load_type), .flush(flush),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_W_addr(reg_W_addr), .wdata(wdata), .reg_we(reg_we),
    .err_timeout(err_timeout), .err_misalign(err_misalign),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] alu,
                       input logic rd, input logic [2:0] lt);
    in_valid = 1'b1; in_reg_we = we; in_wr_addr = a;
    in_alu_result = alu; in_mem_read = rd; in_load_type = lt;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_we",    32'(reg_we), 32'd0);
    chk("rst_addr",  32'(reg_W_addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_errs",  32'({err_timeout, err_misalign, err_spurious}), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b1;

    // single non-load
    issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'b010);
    tick();
    chk("nl_we",    32'(reg_we), 32'd1);
    chk("nl_addr",  32'(reg_W_addr), 32'd5);
    chk("nl_wdata", wdata, 32'hDEADBEEF);
    in_valid = 1'b0;
    tick();
    chk("nl_we_off", 32'(reg_we), 32'd0);
    chk("nl_hold",   32'(reg_W_addr), 32'd5);

    // back-to-back r1, r2, r0
    issue(1'b1, 5'd1, 32'd11, 1'b0, 3'b010);
    tick();
    chk("b2b_we1", 32'(reg_we), 32'd1);
    chk("b2b_a1",  32'(reg_W_addr), 32'd1);
    chk("b2b_rdy", 32'(in_ready), 32'd1);
    issue(1'b1, 5'd2, 32'd22, 1'b0, 3'b010);
    tick();
    chk("b2b_we2", 32'(reg_we), 32'd1);
    chk("b2b_d2",  wdata, 32'd22);
    issue(1'b1, 5'd0, 32'd33, 1'b0, 3'b010);
    tick();
    chk("b2b_we0", 32'(reg_we), 32'd0);
    chk("b2b_rdy3", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();

    // lb offset 3, response after two idle wait cycles
    issue(1'b1, 5'd7, 32'h0000_1003, 1'b1, 3'b000);
    tick();
    chk("lb_rdy0", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("lb_rdy1", 32'(in_ready), 32'd0);
    chk("lb_we_wait", 32'(reg_we), 32'd0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80AA55CC;
    tick();
    dmem_rvalid = 1'b0;
    chk("lb_we",    32'(reg_we), 32'd1);
    chk("lb_addr",  32'(reg_W_addr), 32'd7);
    chk("lb_wdata", wdata, 32'hFFFFFF80);
    chk("lb_rdy",   32'(in_ready), 32'd1);
    tick();
    chk("lb_we_off", 32'(reg_we), 32'd0);

    // lhu offset 2
    issue(1'b1, 5'd8, 32'h0000_2002, 1'b1, 3'b101);
    tick();
    in_valid = 1'b0;
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    chk("lhu_we",    32'(reg_we), 32'd1);
    chk("lhu_wdata", wdata, 32'h000080AA);

    // lh offset 0 with a negative halfword
    issue(1'b1, 5'd6, 32'h0000_2000, 1'b1, 3'b001);
    tick();
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_9ABC;
    tick();
    dmem_rvalid = 1'b0;
    chk("lh_wdata", wdata, 32'hFFFF9ABC);
    chk("lh_mis0",  32'(err_misalign), 32'd0);

    // misaligned lw
    issue(1'b1, 5'd9, 32'h0000_3001, 1'b1, 3'b010);
    tick();
    in_valid = 1'b0;
    chk("mis_err", 32'(err_misalign), 32'd1);
    chk("mis_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("mis_we", 32'(reg_we), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_rvalid = 1'b0;
    chk("mis_drop_we", 32'(reg_we), 32'd0);
    chk("mis_rdy1",    32'(in_ready), 32'd1);
    chk("mis_spur0",   32'(err_spurious), 32'd0);
    chk("mis_wd_hold", wdata, 32'hFFFF9ABC);

    // timeout: 16 edges after the accept edge
    issue(1'b1, 5'd10, 32'h0000_4000, 1'b1, 3'b010);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_pre",     32'(err_timeout), 32'd0);
    chk("to_pre_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_rdy", 32'(in_ready), 32'd1);
    chk("to_we",  32'(reg_we), 32'd0);
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    chk("to_spur", 32'(err_spurious), 32'd1);

    // flush while waiting, response arrives later
    issue(1'b1, 5'd11, 32'h0000_5000, 1'b1, 3'b000);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_rdy0", 32'(in_ready), 32'd0);
    tick();
    chk("fl_rdy1", 32'(in_ready), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0042;
    tick();
    dmem_rvalid = 1'b0;
    chk("fl_we",  32'(reg_we), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);

    // flush together with an accept in IDLE drops the instruction
    issue(1'b1, 5'd12, 32'h0000_0077, 1'b0, 3'b010);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fla_we",   32'(reg_we), 32'd0);
    chk("fla_addr", 32'(reg_W_addr), 32'd6);
    chk("fla_rdy",  32'(in_ready), 32'd1);

    // reset in the middle of a load wait
    issue(1'b1, 5'd13, 32'h0000_6000, 1'b1, 3'b000);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_wait", 32'(in_ready), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("mr_we",    32'(reg_we), 32'd0);
    chk("mr_addr",  32'(reg_W_addr), 32'd0);
    chk("mr_wdata", wdata, 32'd0);
    chk("mr_errs",  32'({err_timeout, err_misalign, err_spurious}), 32'd0);
    chk("mr_rdy",   32'(in_ready), 32'd1);
    tick();
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_00FF;
    tick();
    dmem_rvalid = 1'b0;
    chk("mr_spur", 32'(err_spurious), 32'd1);
    chk("mr_nowe", 32'(reg_we), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
